mmio_rd_arbiter: RTL and testbench
==================================

// Module: mmio_rd_arbiter
// PURPOSE
//  Shares the single MMIO read device (RTC, CLINT mtimecmp) between two requesters:
//  port 0 = instruction side, port 1 = data side (LSU).
//  Arbitrates round-robin and sequences the device start/req/ack handshake.
//  Returns read data or an error response to the granted port.
//  Sits between the core's MMIO decode path and mem_mmio; one transaction in flight.
// PARAMETERS
//  TIMEOUT_CYCLES  16  WAIT-state cycles without dev_req before an error response (>=2)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  m0_valid    in   1   port 0 request; level, held until m0_ready
//  m0_addr     in   64  port 0 read address
//  m0_ready    out  1   one-cycle completion pulse to port 0
//  m0_rdata    out  64  port 0 read data; valid while m0_ready=1
//  m0_err      out  1   with m0_ready: unsupported address or timeout
//  m1_valid, m1_addr, m1_ready, m1_rdata, m1_err: same as port 0, for port 1
//  dev_start   out  1   one-cycle start pulse to device
//  dev_ren     out  1   device read enable; held from ISSUE through WAIT
//  dev_raddr   out  64  device address; stable while dev_ren=1
//  dev_req     in   1   device data-ready (level, set 1 cycle after start)
//  dev_rdata   in   64  device read data; valid while dev_req=1
//  dev_ack     out  1   clears dev_req; held until dev_req observed low
// BEHAVIOUR
//  All outputs registered. Reset value: all outputs 0; state IDLE; last_grant=1, so port 0 wins first tie.
//  Address decode: supported addresses are `DEV_RTC and `DEV_MTIMECMP only.
//  FSM states: IDLE, ISSUE, WAIT, ACK, RESP.
//  - IDLE: if any valid, grant (RR: the port not last_grant wins a tie; a single valid port wins alone).
//    Latch addr and grant; update last_grant.
//    Supported addr -> ISSUE, drive dev_start=1, dev_ren=1, dev_raddr=addr.
//    Unsupported -> RESP with err=1, rdata=0; device untouched.
//  - ISSUE: dev_start back to 0, dev_ren held; clear timeout counter -> WAIT.
//  - WAIT: dev_ren held. If dev_req=1: latch dev_rdata into mN_rdata, pulse mN_ready, set dev_ack=1 -> ACK.
//    Else count; count==TIMEOUT_CYCLES-1: pulse mN_ready with err=1, rdata=0, dev_ren=0 -> IDLE.
//  - ACK: dev_ren=0, dev_ack held while dev_req=1. dev_req=0 sampled -> dev_ack=0 -> IDLE.
//  - RESP: pulse mN_ready (err as decided) -> IDLE.
//  Latency: supported read, device responding 1 cycle after start.
//    - m_ready is high in the cycle after the 2nd edge following valid sampled in IDLE.
//    - Next grant is no earlier than 4 edges after the first sample.
//    - Unsupported address: m_ready 2 edges after sample.
//  m_ready/m_err pulses last exactly 1 cycle and only on the granted port.
//  The non-granted port sees 0 on ready/err; its rdata holds the last value.
//  Simultaneous events:
//    - Both valid -> RR.
//    - A new valid arriving during a transaction waits; it is not dropped.
//    - Valid dropped mid-transaction (protocol violation): the transaction still completes and ready is still pulsed.
//  dev_req seen in IDLE/ISSUE (stale): ignored.
//  Reset mid-operation returns to IDLE with all outputs 0 in the next cycle. The device shares rst.
//  Timeout counter width: $clog2(TIMEOUT_CYCLES)+1; saturates, never wraps.
// STRUCTURE
//  Constants in defines.v: `DEV_RTC, `DEV_MTIMECMP (existing).
//  New in defines.v: MMIO_ARB_IDLE..MMIO_ARB_RESP state encodings (3 bits).
//  Sub-module rr_arbiter2: inputs req[1:0], last_grant; outputs grant, any.
//  Combinational, reusable for other 2-master shares.
//  FSM, address/data latches and timeout counter live in mmio_rd_arbiter.
// TESTING
//  1. m0 reads `DEV_RTC, device returns 64'h1234 -> m0_ready pulse 1 cycle, m0_rdata=64'h1234, m0_err=0.
//     Exactly one dev_start; dev_ack held until dev_req low.
//  2. m0 and m1 valid same cycle, both `DEV_MTIMECMP -> m0 served first, then m1.
//     Repeat with both valid -> m0 then m1 order alternates correctly (last_grant toggles).
//  3. m1 reads 64'h0200_0000 (unsupported) -> m1_ready+m1_err 2 edges later, m1_rdata=0.
//     No dev_start or dev_ren observed.
//  4. Device model never raises dev_req -> m0_ready+m0_err after 16 WAIT cycles.
//     dev_ren drops; the next request is served normally.
//  5. rst asserted in WAIT and again in ACK -> next cycle all outputs 0, state IDLE.
//     A pending m1 request is then granted fresh.
//  6. m1 valid raised while m0 transaction in ACK -> m1 granted only after dev_req low and dev_ack dropped.
//     m0 sees no second ready pulse.

Source files
------------

// File: rtl/mmio_rd_arbiter_pkg.sv
// Shared constants, state encoding and address decode for the MMIO read arbiter.
package mmio_rd_arbiter_pkg;

   localparam int unsigned MMIO_ADDR_W = 64;
   localparam int unsigned MMIO_DATA_W = 64;

   // Device addresses served by mem_mmio (RTC and CLINT mtimecmp)
   localparam logic [MMIO_ADDR_W-1:0] DEV_RTC      = 64'h0000_0000_0200_bff8;
   localparam logic [MMIO_ADDR_W-1:0] DEV_MTIMECMP = 64'h0000_0000_0200_4000;

   // Arbiter FSM state encodings
   typedef enum logic [2:0] {
      MMIO_ARB_IDLE  = 3'd0,
      MMIO_ARB_ISSUE = 3'd1,
      MMIO_ARB_WAIT  = 3'd2,
      MMIO_ARB_ACK   = 3'd3,
      MMIO_ARB_RESP  = 3'd4
   } mmio_arb_state_e;

   // True for the addresses the shared device actually implements
   function automatic logic mmio_addr_supported(input logic [MMIO_ADDR_W-1:0] addr);
      return (addr == DEV_RTC) || (addr == DEV_MTIMECMP);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; purely combinational so any 2-master share can reuse it.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       any
);

   // On a tie the port that did not win last time is granted; a lone requester always wins
   always_comb begin
      any   = |req;
      grant = 1'b0;
      if (req == 2'b11) begin
         grant = ~last_grant;
      end else begin
         grant = req[1];
      end
   end

endmodule

// File: rtl/mmio_rd_arbiter.sv
// Shares the single MMIO read device between the instruction port (0) and the LSU port (1).
// One transaction in flight; sequences the device start/req/ack handshake and returns
// read data or an error pulse to whichever port was granted.
module mmio_rd_arbiter
   import mmio_rd_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid,
   input  logic [63:0] m0_addr,
   output logic        m0_ready,
   output logic [63:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_valid,
   input  logic [63:0] m1_addr,
   output logic        m1_ready,
   output logic [63:0] m1_rdata,
   output logic        m1_err,
   output logic        dev_start,
   output logic        dev_ren,
   output logic [63:0] dev_raddr,
   input  logic        dev_req,
   input  logic [63:0] dev_rdata,
   output logic        dev_ack
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   mmio_arb_state_e    state_q;
   logic               gnt_q;
   logic               last_grant_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               arb_grant;
   logic               arb_any;
   logic [63:0]        req_addr;

   rr_arbiter2 u_rr (
      .req        ({m1_valid, m0_valid}),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .any        (arb_any)
   );

   // Address of the port the arbiter would grant this cycle
   always_comb begin
      req_addr = arb_grant ? m1_addr : m0_addr;
   end

   // Arbitration FSM, address/data latches, timeout counter and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= MMIO_ARB_IDLE;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         m0_ready     <= 1'b0;
         m0_rdata     <= '0;
         m0_err       <= 1'b0;
         m1_ready     <= 1'b0;
         m1_rdata     <= '0;
         m1_err       <= 1'b0;
         dev_start    <= 1'b0;
         dev_ren      <= 1'b0;
         dev_raddr    <= '0;
         dev_ack      <= 1'b0;
      end else begin
         m0_ready  <= 1'b0;
         m0_err    <= 1'b0;
         m1_ready  <= 1'b0;
         m1_err    <= 1'b0;
         dev_start <= 1'b0;

         case (state_q)
            MMIO_ARB_IDLE: begin
               if (arb_any) begin
                  gnt_q        <= arb_grant;
                  last_grant_q <= arb_grant;
                  if (mmio_addr_supported(req_addr)) begin
                     dev_start <= 1'b1;
                     dev_ren   <= 1'b1;
                     dev_raddr <= req_addr;
                     state_q   <= MMIO_ARB_ISSUE;
                  end else begin
                     state_q   <= MMIO_ARB_RESP;
                  end
               end
            end

            MMIO_ARB_ISSUE: begin
               cnt_q   <= '0;
               state_q <= MMIO_ARB_WAIT;
            end

            MMIO_ARB_WAIT: begin
               if (dev_req) begin
                  if (gnt_q) begin
                     m1_ready <= 1'b1;
                     m1_rdata <= dev_rdata;
                  end else begin
                     m0_ready <= 1'b1;
                     m0_rdata <= dev_rdata;
                  end
                  dev_ack <= 1'b1;
                  dev_ren <= 1'b0;
                  state_q <= MMIO_ARB_ACK;
               end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  if (gnt_q) begin
                     m1_ready <= 1'b1;
                     m1_err   <= 1'b1;
                     m1_rdata <= '0;
                  end else begin
                     m0_ready <= 1'b1;
                     m0_err   <= 1'b1;
                     m0_rdata <= '0;
                  end
                  dev_ren <= 1'b0;
                  state_q <= MMIO_ARB_IDLE;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            MMIO_ARB_ACK: begin
               dev_ren <= 1'b0;
               if (!dev_req) begin
                  dev_ack <= 1'b0;
                  state_q <= MMIO_ARB_IDLE;
               end
            end

            MMIO_ARB_RESP: begin
               // Only unsupported addresses reach here, so the response is always an error
               if (gnt_q) begin
                  m1_ready <= 1'b1;
                  m1_err   <= 1'b1;
                  m1_rdata <= '0;
               end else begin
                  m0_ready <= 1'b1;
                  m0_err   <= 1'b1;
                  m0_rdata <= '0;
               end
               state_q <= MMIO_ARB_IDLE;
            end

            default: begin
               dev_ren <= 1'b0;
               dev_ack <= 1'b0;
               state_q <= MMIO_ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_rd_arbiter.sv
// Directed bench for mmio_rd_arbiter with a small behavioural model of the MMIO device.
module tb_mmio_rd_arbiter;
   import mmio_rd_arbiter_pkg::*;

   logic        clk;
   logic        rst;
   logic        m0_valid;
   logic [63:0] m0_addr;
   logic        m0_ready;
   logic [63:0] m0_rdata;
   logic        m0_err;
   logic        m1_valid;
   logic [63:0] m1_addr;
   logic        m1_ready;
   logic [63:0] m1_rdata;
   logic        m1_err;
   logic        dev_start;
   logic        dev_ren;
   logic [63:0] dev_raddr;
   logic        dev_req;
   logic [63:0] dev_rdata;
   logic        dev_ack;

   logic        resp_en;
   logic [63:0] rtc_val;
   logic [63:0] cmp_val;
   int          n_start;
   int          n_ren;
   int          total;
   int          bad;

   mmio_rd_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_valid  (m0_valid),
      .m0_addr   (m0_addr),
      .m0_ready  (m0_ready),
      .m0_rdata  (m0_rdata),
      .m0_err    (m0_err),
      .m1_valid  (m1_valid),
      .m1_addr   (m1_addr),
      .m1_ready  (m1_ready),
      .m1_rdata  (m1_rdata),
      .m1_err    (m1_err),
      .dev_start (dev_start),
      .dev_ren   (dev_ren),
      .dev_raddr (dev_raddr),
      .dev_req   (dev_req),
      .dev_rdata (dev_rdata),
      .dev_ack   (dev_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Device: raises req one cycle after start (unless muted), drops it when ack is seen
   always @(posedge clk) begin
      if (rst) begin
         dev_req   <= 1'b0;
         dev_rdata <= '0;
      end else if (dev_start && resp_en) begin
         dev_req   <= 1'b1;
         dev_rdata <= (dev_raddr == DEV_RTC) ? rtc_val : cmp_val;
      end else if (dev_ack) begin
         dev_req   <= 1'b0;
      end
   end

   // Running counts of start pulses and read-enable cycles
   initial begin
      n_start = 0;
      n_ren   = 0;
   end
   always @(negedge clk) begin
      if (dev_start) n_start = n_start + 1;
      if (dev_ren)   n_ren   = n_ren + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      logic [6:0] ctl;
      ctl = {m0_ready, m0_err, m1_ready, m1_err, dev_start, dev_ren, dev_ack};
      chk({tag, "_ctl"},   64'(ctl), 64'd0);
      chk({tag, "_m0d"},   m0_rdata, 64'd0);
      chk({tag, "_m1d"},   m1_rdata, 64'd0);
      chk({tag, "_raddr"}, dev_raddr, 64'd0);
   endtask

   task automatic wait_rdy(input int port, input int budget, output int cyc);
      cyc = -1;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if ((port == 0 && m0_ready) || (port == 1 && m1_ready)) begin
            cyc = c;
            break;
         end
      end
   endtask

   task automatic settle();
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst      = 1'b1;
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero(tag);
      rst = 1'b0;
   endtask

   // Single-port read: raise valid, wait for ready, check latency/data/err, drop valid
   task automatic rd(input string tag, input int port, input logic [63:0] addr,
                     input int exp_c, input logic [63:0] exp_d, input logic exp_e);
      int c;
      if (port == 0) begin m0_valid = 1'b1; m0_addr = addr; end
      else           begin m1_valid = 1'b1; m1_addr = addr; end
      wait_rdy(port, 40, c);
      chk({tag, "_lat"}, 64'(c), 64'(exp_c));
      chk({tag, "_data"}, (port == 0) ? m0_rdata : m1_rdata, exp_d);
      chk({tag, "_err"}, 64'((port == 0) ? m0_err : m1_err), 64'(exp_e));
      chk({tag, "_other"}, 64'((port == 0) ? m1_ready : m0_ready), 64'd0);
      if (port == 0) m0_valid = 1'b0;
      else           m1_valid = 1'b0;
   endtask

   initial begin
      int c;
      int s0;
      int r0;
      int m0_pulses;
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      m0_addr  = '0;
      m1_addr  = '0;
      resp_en  = 1'b1;
      rtc_val  = 64'h1234;
      cmp_val  = 64'hcafe_0001;

      do_reset("rst0");

      // 1: m0 reads RTC, cycle by cycle
      s0 = n_start;
      @(negedge clk);
      m0_valid = 1'b1;
      m0_addr  = DEV_RTC;
      @(negedge clk);
      chk("t1_start", 64'(dev_start), 64'd1);
      chk("t1_ren1", 64'(dev_ren), 64'd1);
      chk("t1_raddr", dev_raddr, DEV_RTC);
      @(negedge clk);
      chk("t1_start0", 64'(dev_start), 64'd0);
      chk("t1_ren2", 64'(dev_ren), 64'd1);
      @(negedge clk);
      chk("t1_ready", 64'(m0_ready), 64'd1);
      chk("t1_data", m0_rdata, 64'h1234);
      chk("t1_err", 64'(m0_err), 64'd0);
      chk("t1_ack1", 64'(dev_ack), 64'd1);
      m0_valid = 1'b0;
      @(negedge clk);
      chk("t1_pulse", 64'(m0_ready), 64'd0);
      chk("t1_ackhold", 64'(dev_ack), 64'd1);
      @(negedge clk);
      chk("t1_ackdrop", 64'(dev_ack), 64'd0);
      chk("t1_nstart", 64'(n_start - s0), 64'd1);
      settle();

      // 2: ties from reset go m0 first, then alternate by last grant
      do_reset("rst2");
      for (int rep = 0; rep < 2; rep++) begin
         cmp_val  = 64'hcafe_0001 + 64'(rep);
         m0_valid = 1'b1; m0_addr = DEV_MTIMECMP;
         m1_valid = 1'b1; m1_addr = DEV_MTIMECMP;
         wait_rdy(0, 20, c);
         chk("t2_m0lat", 64'(c), 64'd3);
         chk("t2_m1idle", 64'(m1_ready), 64'd0);
         chk("t2_m0data", m0_rdata, cmp_val);
         m0_valid = 1'b0;
         wait_rdy(1, 20, c);
         chk("t2_m1lat", 64'(c), 64'd5);
         chk("t2_m1data", m1_rdata, cmp_val);
         m1_valid = 1'b0;
         settle();
      end
      rd("t2_solo", 0, DEV_RTC, 3, 64'h1234, 1'b0);
      settle();
      cmp_val  = 64'hcafe_0003;
      m0_valid = 1'b1; m0_addr = DEV_MTIMECMP;
      m1_valid = 1'b1; m1_addr = DEV_MTIMECMP;
      wait_rdy(1, 20, c);
      chk("t2_rr_m1lat", 64'(c), 64'd3);
      chk("t2_rr_m0idle", 64'(m0_ready), 64'd0);
      m1_valid = 1'b0;
      wait_rdy(0, 20, c);
      chk("t2_rr_m0lat", 64'(c), 64'd5);
      chk("t2_rr_m0data", m0_rdata, 64'hcafe_0003);
      settle();

      // 3: unsupported address on m1, device untouched
      s0 = n_start;
      r0 = n_ren;
      rd("t3", 1, 64'h0000_0000_0200_0000, 2, 64'd0, 1'b1);
      settle();
      chk("t3_nstart", 64'(n_start - s0), 64'd0);
      chk("t3_nren", 64'(n_ren - r0), 64'd0);

      // 4: device silent -> timeout error, then normal service resumes
      resp_en = 1'b0;
      rd("t4_to", 0, DEV_RTC, 18, 64'd0, 1'b1);
      chk("t4_ren", 64'(dev_ren), 64'd0);
      resp_en = 1'b1;
      rtc_val = 64'h5555;
      rd("t4_after", 0, DEV_RTC, 3, 64'h5555, 1'b0);
      settle();

      // 5a: reset while in WAIT with m1 pending
      resp_en  = 1'b0;
      m0_valid = 1'b1; m0_addr = DEV_RTC;
      @(negedge clk);
      m1_valid = 1'b1; m1_addr = DEV_MTIMECMP;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("t5w");
      rst      = 1'b0;
      m0_valid = 1'b0;
      resp_en  = 1'b1;
      cmp_val  = 64'hbeef_0005;
      wait_rdy(1, 20, c);
      chk("t5w_lat", 64'(c), 64'd3);
      chk("t5w_data", m1_rdata, 64'hbeef_0005);
      settle();

      // 5b: reset while in ACK with m1 pending
      m0_valid = 1'b1; m0_addr = DEV_RTC;
      wait_rdy(0, 20, c);
      chk("t5a_m0lat", 64'(c), 64'd3);
      rst      = 1'b1;
      m0_valid = 1'b0;
      m1_valid = 1'b1; m1_addr = DEV_MTIMECMP;
      @(negedge clk);
      chk_zero("t5a");
      rst     = 1'b0;
      cmp_val = 64'hbeef_0006;
      wait_rdy(1, 20, c);
      chk("t5a_lat", 64'(c), 64'd3);
      chk("t5a_data", m1_rdata, 64'hbeef_0006);
      settle();

      // 6: m1 arrives while m0 is in ACK; granted only after the handshake closes
      rtc_val  = 64'h6666;
      m0_valid = 1'b1; m0_addr = DEV_RTC;
      wait_rdy(0, 20, c);
      chk("t6_m0lat", 64'(c), 64'd3);
      m0_valid  = 1'b0;
      m1_valid  = 1'b1; m1_addr = DEV_MTIMECMP;
      cmp_val   = 64'h7777;
      m0_pulses = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (m0_ready) m0_pulses++;
         if (k == 1) begin
            chk("t6_ackheld", 64'(dev_ack), 64'd1);
            chk("t6_nostart1", 64'(dev_start), 64'd0);
         end
         if (k == 2) begin
            chk("t6_ackdrop", 64'(dev_ack), 64'd0);
            chk("t6_nostart2", 64'(dev_start), 64'd0);
         end
         if (k == 3) chk("t6_start", 64'(dev_start), 64'd1);
         if (k == 5) begin
            chk("t6_m1rdy", 64'(m1_ready), 64'd1);
            chk("t6_m1data", m1_rdata, 64'h7777);
         end
      end
      chk("t6_m0pulses", 64'(m0_pulses), 64'd0);
      chk("t6_m0hold", m0_rdata, 64'h6666);
      settle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
